random_spawn_ctrl: RTL and testbench
====================================

# random_spawn_ctrl

Random spawn controller for the game-object engine: it consumes words from the 30-bit LFSR and emits spawn commands to the object manager. Every `INTERVAL_FRAMES` frames it pulses the LFSR's `gen` input and samples the resulting word. It slices the word into position, type and speed fields, and range-checks the position against the playfield, redrawing when the position is out of range. An accepted spawn is offered on a valid/ready handshake.

## Interface
- `SCREEN_W`, 640: playfield width in pixels.
- `SCREEN_H`, 480: playfield height in pixels.
- `OBJ_W`, 32: object width; maximum legal x is `X_MAX = SCREEN_W-OBJ_W` (608).
- `OBJ_H`, 32: object height; maximum legal y is `Y_MAX = SCREEN_H-OBJ_H` (448).
- `INTERVAL_FRAMES`, 60: frame ticks between spawn attempts, minimum 1.
- `MAX_RETRY`, 7: number of redraws before the fold fallback.
- `MIN_GAP`, 64: minimum horizontal gap from the previous spawn; used only with `SPAWN_MIN_GAP_EN`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: spawning allowed.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `rnd_data` in 30: LFSR output word.
- `rnd_gen` out 1: one-cycle advance request to the LFSR.
- `spawn_valid` out 1: spawn command offered.
- `spawn_ready` in 1: object manager accepts the command.
- `spawn_x` out 10: left edge of the spawned object.
- `spawn_y` out 9: top edge of the spawned object.
- `spawn_type` out 2: object type.
- `spawn_speed` out 3: object speed, range 1..7.

## Operation
- **Field slicing from `rnd_data`:**
  - x = `[9:0]`
  - y = `[18:10]`
  - type = `[20:19]`
  - speed = `[23:21]`; a raw value of 0 maps to 1.
- **States and transitions:**
  - IDLE: leave to WAIT when `enable`=1.
  - WAIT: count `frame_tick` pulses. On the tick where the count equals `INTERVAL_FRAMES-1`, clear the count and go to DRAW.
  - DRAW: `rnd_gen`=1 for exactly this cycle. Go to SETTLE.
  - SETTLE: the LFSR word updates during this cycle. Go to CHECK.
  - CHECK: sample `rnd_data` and evaluate it.
    - Accept if x ≤ `X_MAX` and y ≤ `Y_MAX`, plus the gap rule when configured. Register the fields and go to OFFER.
    - On reject with retry < `MAX_RETRY`: retry++ and go to DRAW.
    - On reject with retry = `MAX_RETRY`: apply the fold, then go to OFFER.
  - OFFER: `spawn_valid`=1 with the payload held stable. When `spawn_valid` and `spawn_ready` are both high, clear the retry count, update `last_x`, and go to WAIT (or to IDLE if `enable`=0).
- **Fold fallback:** each out-of-range coordinate c becomes c-(MAX+1). This is always in range for the default parameters. The fold ignores the gap rule.
- **`enable`=0** in WAIT, DRAW, SETTLE or CHECK: go to IDLE, clear the frame count and retry count. An OFFER is never retracted; it completes its handshake first.
- **`frame_tick`** pulses arriving outside WAIT are ignored. The interval restarts after each handshake.
- **Reset:**
  - state=IDLE; all counters=0; `last_x`=0.
  - `rnd_gen`=0, `spawn_valid`=0, payload=0.
  - Reset mid-OFFER drops the pending spawn.

## Timing
- `rnd_gen` is high in the cycle after the edge that samples the terminal `frame_tick`.
- If the first draw is accepted, `spawn_valid` rises 4 cycles after the terminal-tick edge.
- Each rejection adds 3 cycles (DRAW, SETTLE, CHECK).
- Worst case to `spawn_valid` is 1+3·(`MAX_RETRY`+1) cycles.
- The handshake completes on any edge with `spawn_valid`&`spawn_ready`. With `spawn_ready` held high, `spawn_valid` is high for exactly 1 cycle.
- `rnd_gen` is never asserted outside DRAW, so at most one LFSR advance occurs per 3 cycles.

## Configuration
- `SPAWN_MIN_GAP_EN` defined:
  - CHECK also rejects when |x − `last_x`| < `MIN_GAP`.
  - `last_x` is a 10-bit register updated on each handshake.
- `SPAWN_MIN_GAP_EN` undefined:
  - No gap rule and no `last_x` register.
  - Only the bounds check applies.

## Structure
- Package `spawn_pkg`: state enum; field slice constants (X_LSB, Y_LSB, TYPE_LSB, SPEED_LSB); speed-zero remap value.
- Sub-module `spawn_range_check`:
  - Bounds check, gap check and fold arithmetic for one word.
  - Outputs `accept` and folded x/y.
  - Instantiated once.

## Test plan
- Accept on first draw: `rnd_data`=30'h0004_0064, terminal `frame_tick`, `spawn_ready`=1 → `rnd_gen` 1 cycle later; `spawn_valid` 4 cycles after the tick with x=100, y=256, type=0, speed=1.
- Single rejection: first word x=1023 (30'h0000_03FF), then 30'h0004_0064 → exactly two `rnd_gen` pulses; `spawn_valid` 7 cycles after the tick with x=100.
- Retry exhaustion: hold `rnd_data`=30'h0007_FFFF → 8 `rnd_gen` pulses, then x=414, y=62.
- Backpressure: `spawn_ready`=0 for 10 cycles → `spawn_valid` and payload stable throughout; exactly one handshake, then the next spawn after 60 more frame ticks.
- Enable and reset: deassert `enable` in WAIT → IDLE with no `rnd_gen`. Assert `reset` mid-OFFER → `spawn_valid`=0 immediately (asynchronous), state IDLE.
- Gap (with `SPAWN_MIN_GAP_EN`): `last_x`=100, new x=130 → rejected and redrawn; new x=200 → accepted.

Source files
------------

// File: rtl/spawn_pkg.sv
// Shared types and rnd_data field layout for the random spawn controller.
// Optional feature macro used by this block: SPAWN_MIN_GAP_EN.
package spawn_pkg;

    localparam int unsigned RND_W     = 30;
    localparam int unsigned X_W       = 10;
    localparam int unsigned Y_W       = 9;
    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned SPEED_W   = 3;

    localparam int unsigned X_LSB     = 0;
    localparam int unsigned Y_LSB     = 10;
    localparam int unsigned TYPE_LSB  = 19;
    localparam int unsigned SPEED_LSB = 21;

    // A raw speed of zero would spawn a motionless object; it is promoted to this value.
    localparam logic [SPEED_W-1:0] SPEED_ZERO_REMAP = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DRAW,
        S_SETTLE,
        S_CHECK,
        S_OFFER
    } spawn_state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [TYPE_W-1:0]  kind;
        logic [SPEED_W-1:0] speed;
    } spawn_cmd_t;

    function automatic logic [SPEED_W-1:0] remap_speed(input logic [SPEED_W-1:0] raw);
        return (raw == '0) ? SPEED_ZERO_REMAP : raw;
    endfunction

endpackage

// File: rtl/spawn_range_check.sv
// Playfield bounds check, optional horizontal gap check and fold fallback for one word.
// Optional feature macro: SPAWN_MIN_GAP_EN (adds the last_x gap rule).
module spawn_range_check
    import spawn_pkg::*;
#(
    parameter int unsigned X_MAX   = 608,
    parameter int unsigned Y_MAX   = 448,
    parameter int unsigned MIN_GAP = 64
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
`ifdef SPAWN_MIN_GAP_EN
    input  logic [X_W-1:0] last_x,
`endif
    output logic           accept,
    output logic [X_W-1:0] x_fold,
    output logic [Y_W-1:0] y_fold
);

    localparam int unsigned    DIST_W  = X_W + 1;
    localparam logic [X_W-1:0] X_MAX_V = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MAX_V = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_WRAP  = X_W'(X_MAX + 1);
    localparam logic [Y_W-1:0] Y_WRAP  = Y_W'(Y_MAX + 1);

    logic x_ok;
    logic y_ok;
    logic gap_ok;

    assign x_ok = (x <= X_MAX_V);
    assign y_ok = (y <= Y_MAX_V);

    // Out-of-range coordinates wrap back by one playfield span; in-range ones pass through.
    assign x_fold = x_ok ? x : x - X_WRAP;
    assign y_fold = y_ok ? y : y - Y_WRAP;

`ifdef SPAWN_MIN_GAP_EN
    logic [DIST_W-1:0] dist;

    // Absolute horizontal distance from the previously handed-off spawn.
    assign dist   = (x >= last_x) ? {1'b0, x - last_x} : {1'b0, last_x - x};
    assign gap_ok = (dist >= DIST_W'(MIN_GAP));
`else
    assign gap_ok = 1'b1;
`endif

    assign accept = x_ok & y_ok & gap_ok;

endmodule

// File: rtl/random_spawn_ctrl.sv
// Random spawn controller: paces LFSR draws by frame count, range-checks the word,
// redraws or folds on rejection, and offers the spawn on a valid/ready handshake.
// Optional feature macro: SPAWN_MIN_GAP_EN (minimum horizontal gap from the last spawn).
module random_spawn_ctrl
    import spawn_pkg::*;
#(
    parameter int unsigned SCREEN_W        = 640,
    parameter int unsigned SCREEN_H        = 480,
    parameter int unsigned OBJ_W           = 32,
    parameter int unsigned OBJ_H           = 32,
    parameter int unsigned INTERVAL_FRAMES = 60,
    parameter int unsigned MAX_RETRY       = 7,
    parameter int unsigned MIN_GAP         = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic [RND_W-1:0]   rnd_data,
    output logic               rnd_gen,
    output logic               spawn_valid,
    input  logic               spawn_ready,
    output logic [X_W-1:0]     spawn_x,
    output logic [Y_W-1:0]     spawn_y,
    output logic [TYPE_W-1:0]  spawn_type,
    output logic [SPEED_W-1:0] spawn_speed
);

    localparam int unsigned X_MAX = SCREEN_W - OBJ_W;
    localparam int unsigned Y_MAX = SCREEN_H - OBJ_H;
    localparam int unsigned FC_W  = (INTERVAL_FRAMES > 1) ? $clog2(INTERVAL_FRAMES) : 1;
    localparam int unsigned RC_W  = $clog2(MAX_RETRY + 2);

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(INTERVAL_FRAMES - 1);
    localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);

    spawn_state_e     state;
    spawn_state_e     next_state;
    logic [FC_W-1:0]  frame_cnt;
    logic [FC_W-1:0]  frame_cnt_nxt;
    logic [RC_W-1:0]  retry_cnt;
    logic [RC_W-1:0]  retry_nxt;
    logic             load_cmd;
    spawn_cmd_t       cmd_q;

    logic [X_W-1:0]     raw_x;
    logic [Y_W-1:0]     raw_y;
    logic [TYPE_W-1:0]  raw_type;
    logic [SPEED_W-1:0] raw_speed;
    logic               accept;
    logic [X_W-1:0]     chk_x;
    logic [Y_W-1:0]     chk_y;
    logic               unused_rnd_hi;

    assign raw_x         = rnd_data[X_LSB +: X_W];
    assign raw_y         = rnd_data[Y_LSB +: Y_W];
    assign raw_type      = rnd_data[TYPE_LSB +: TYPE_W];
    assign raw_speed     = rnd_data[SPEED_LSB +: SPEED_W];
    assign unused_rnd_hi = ^rnd_data[RND_W-1:SPEED_LSB+SPEED_W];

`ifdef SPAWN_MIN_GAP_EN
    logic [X_W-1:0] last_x;
`endif

    spawn_range_check #(
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX),
        .MIN_GAP (MIN_GAP)
    ) u_range_check (
        .x      (raw_x),
        .y      (raw_y),
`ifdef SPAWN_MIN_GAP_EN
        .last_x (last_x),
`endif
        .accept (accept),
        .x_fold (chk_x),
        .y_fold (chk_y)
    );

    // Next-state, frame pacing and retry bookkeeping.
    always_comb begin
        next_state    = state;
        frame_cnt_nxt = frame_cnt;
        retry_nxt     = retry_cnt;
        load_cmd      = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (enable) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    next_state    = S_IDLE;
                    frame_cnt_nxt = '0;
                    retry_nxt     = '0;
                end else if (frame_tick) begin
                    if (frame_cnt == FC_LAST) begin
                        frame_cnt_nxt = '0;
                        next_state    = S_DRAW;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            S_DRAW, S_SETTLE: begin
                if (!enable) begin
                    next_state    = S_IDLE;
                    frame_cnt_nxt = '0;
                    retry_nxt     = '0;
                end else begin
                    next_state = (state == S_DRAW) ? S_SETTLE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (!enable) begin
                    next_state    = S_IDLE;
                    frame_cnt_nxt = '0;
                    retry_nxt     = '0;
                end else if (accept || (retry_cnt == RC_MAX)) begin
                    load_cmd   = 1'b1;
                    next_state = S_OFFER;
                end else begin
                    retry_nxt  = retry_cnt + 1'b1;
                    next_state = S_DRAW;
                end
            end
            S_OFFER: begin
                if (spawn_valid && spawn_ready) begin
                    retry_nxt  = '0;
                    next_state = enable ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State, counters, registered strobes and the held spawn payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            frame_cnt   <= '0;
            retry_cnt   <= '0;
            rnd_gen     <= 1'b0;
            spawn_valid <= 1'b0;
            cmd_q       <= '0;
        end else begin
            state       <= next_state;
            frame_cnt   <= frame_cnt_nxt;
            retry_cnt   <= retry_nxt;
            rnd_gen     <= (next_state == S_DRAW);
            spawn_valid <= (next_state == S_OFFER);
            if (load_cmd) begin
                cmd_q <= '{x: chk_x, y: chk_y, kind: raw_type, speed: remap_speed(raw_speed)};
            end
        end
    end

`ifdef SPAWN_MIN_GAP_EN
    // Remember the x of the last spawn the object manager actually took.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_x <= '0;
        end else if ((state == S_OFFER) && spawn_valid && spawn_ready) begin
            last_x <= cmd_q.x;
        end
    end
`endif

    assign spawn_x     = cmd_q.x;
    assign spawn_y     = cmd_q.y;
    assign spawn_type  = cmd_q.kind;
    assign spawn_speed = cmd_q.speed;

endmodule

// File: tb/tb_random_spawn_ctrl.sv
// Directed bench for random_spawn_ctrl (default build, SPAWN_MIN_GAP_EN undefined).
`timescale 1ns/1ps
module tb_random_spawn_ctrl;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic        frame_tick  = 1'b0;
    logic        spawn_ready = 1'b0;
    logic [29:0] rnd_data    = '0;
    logic        rnd_gen;
    logic        spawn_valid;
    logic [9:0]  spawn_x;
    logic [8:0]  spawn_y;
    logic [1:0]  spawn_type;
    logic [2:0]  spawn_speed;

    logic [29:0] wq[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [29:0] w0;
        logic [29:0] w1;
        bit          two;
        int          lat;
        int          draws;
        int          x;
        int          y;
        int          t;
        int          s;
    } vec_t;

    vec_t vecs[7];

    random_spawn_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .rnd_data    (rnd_data),
        .rnd_gen     (rnd_gen),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .spawn_type  (spawn_type),
        .spawn_speed (spawn_speed)
    );

    always #5 clk = ~clk;

    // LFSR stand-in: each gen pulse loads the next queued word, otherwise the word holds.
    always @(posedge clk) begin
        if (rnd_gen && wq.size() > 0) rnd_data <= wq.pop_front();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive n frame ticks; count cycles where the DUT shows any draw or offer activity.
    task automatic pre_ticks(input int n, output int act);
        act = 0;
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            if (rnd_gen || spawn_valid) act++;
        end
    endtask

    // Called right after the terminal tick is driven; returns cycles to spawn_valid and draw count.
    task automatic run_to_offer(output int lat, output int draws);
        lat   = 0;
        draws = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) frame_tick = 1'b0;
            if (rnd_gen) draws++;
            if (spawn_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, g2, g3, lat, dr;

        vecs[0] = '{30'h0004_0064, 30'h0, 1'b0,  4, 1, 100, 256, 0, 1};
        vecs[1] = '{30'h0000_03FF, 30'h0004_0064, 1'b1, 7, 2, 100, 256, 0, 1};
        vecs[2] = '{30'h0007_FFFF, 30'h0, 1'b0, 25, 8, 414,  62, 0, 1};
        vecs[3] = '{30'h00B7_0260, 30'h0, 1'b0,  4, 1, 608, 448, 2, 5};
        vecs[4] = '{30'h3FF8_0261, 30'h0, 1'b0, 25, 8,   0,   0, 3, 7};
        vecs[5] = '{30'h002F_0400, 30'h0, 1'b0, 25, 8,   0,   0, 1, 1};
        vecs[6] = '{30'h0000_0000, 30'h0, 1'b0,  4, 1,   0,   0, 0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gen",   32'(rnd_gen),     0);
        chk("rst_valid", 32'(spawn_valid), 0);
        chk("rst_x",     32'(spawn_x),     0);
        chk("rst_y",     32'(spawn_y),     0);
        chk("rst_type",  32'(spawn_type),  0);
        chk("rst_speed", 32'(spawn_speed), 0);
        reset = 1'b0;

        // Ticks while disabled must not start anything
        pre_ticks(70, g);
        chk("idle_quiet", 32'(g), 0);
        frame_tick  = 1'b0;
        enable      = 1'b1;
        spawn_ready = 1'b1;
        @(negedge clk);

        // Table of single spawns with ready held high
        for (int i = 0; i < 7; i++) begin
            wq.delete();
            wq.push_back(vecs[i].w0);
            if (vecs[i].two) wq.push_back(vecs[i].w1);
            pre_ticks(59, g);
            chk($sformatf("v%0d_no_early", i), 32'(g), 0);
            frame_tick = 1'b1;
            run_to_offer(lat, dr);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_draws", i),   32'(dr),  32'(vecs[i].draws));
            chk($sformatf("v%0d_x", i),       32'(spawn_x),     32'(vecs[i].x));
            chk($sformatf("v%0d_y", i),       32'(spawn_y),     32'(vecs[i].y));
            chk($sformatf("v%0d_type", i),    32'(spawn_type),  32'(vecs[i].t));
            chk($sformatf("v%0d_speed", i),   32'(spawn_speed), 32'(vecs[i].s));
            @(negedge clk);
            chk($sformatf("v%0d_valid_1cyc", i), 32'(spawn_valid), 0);
        end

        // Backpressure: payload held, ticks during OFFER ignored, interval restarts after handshake
        spawn_ready = 1'b0;
        wq.delete();
        wq.push_back(30'h00B7_0260);
        wq.push_back(30'h0004_0064);
        pre_ticks(59, g);
        frame_tick = 1'b1;
        run_to_offer(lat, dr);
        chk("bp_latency", 32'(lat), 4);
        for (int i = 0; i < 10; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            chk("bp_valid_held", 32'(spawn_valid), 1);
            chk("bp_payload_held", 32'({spawn_x, spawn_y, spawn_type, spawn_speed}),
                32'({10'd608, 9'd448, 2'd2, 3'd5}));
            if (rnd_gen) g++;
        end
        chk("bp_no_gen", 32'(g), 0);
        frame_tick  = 1'b0;
        spawn_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_drop", 32'(spawn_valid), 0);
        pre_ticks(59, g);
        chk("bp_restart_quiet", 32'(g), 0);
        frame_tick = 1'b1;
        run_to_offer(lat, dr);
        chk("bp_next_latency", 32'(lat), 4);
        chk("bp_next_x", 32'(spawn_x), 100);
        @(negedge clk);
        chk("bp_next_valid_1cyc", 32'(spawn_valid), 0);

        // Enable dropped in WAIT clears the frame count
        wq.delete();
        wq.push_back(30'h0004_0064);
        pre_ticks(30, g);
        frame_tick = 1'b0;
        enable     = 1'b0;
        @(negedge clk);
        pre_ticks(5, g2);
        frame_tick = 1'b0;
        enable     = 1'b1;
        @(negedge clk);
        pre_ticks(59, g3);
        chk("en_restart_quiet", 32'(g + g2 + g3), 0);
        frame_tick = 1'b1;
        run_to_offer(lat, dr);
        chk("en_latency", 32'(lat), 4);
        chk("en_draws", 32'(dr), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of an OFFER
        spawn_ready = 1'b0;
        wq.delete();
        wq.push_back(30'h00B7_0260);
        pre_ticks(59, g);
        frame_tick = 1'b1;
        run_to_offer(lat, dr);
        chk("rstoff_latency", 32'(lat), 4);
        #2 reset = 1'b1;
        #1;
        chk("rstoff_valid", 32'(spawn_valid), 0);
        chk("rstoff_payload", 32'({spawn_x, spawn_y, spawn_type, spawn_speed}), 0);
        @(negedge clk);
        reset       = 1'b0;
        spawn_ready = 1'b1;
        @(negedge clk);
        wq.delete();
        wq.push_back(30'h0004_0064);
        pre_ticks(59, g);
        chk("rstoff_restart_quiet", 32'(g), 0);
        frame_tick = 1'b1;
        run_to_offer(lat, dr);
        chk("rstoff_relaunch_latency", 32'(lat), 4);
        chk("rstoff_relaunch_y", 32'(spawn_y), 256);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
